dmem_tile_addr_gen: RTL and testbench

//  Parametrised data-memory address generator for the binary MLP datapath.

---
 rtl/dmem_tile_addr_gen_pkg.sv | 16 +
 rtl/dmem_tile_addr_gen_wrap_counter.sv | 43 ++++
 rtl/dmem_tile_addr_gen.sv | 154 +++++++++++++++
 tb/tb_dmem_tile_addr_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_tile_addr_gen_pkg.sv
// Shared types and width helpers for the dmem tile address generator.
//   agen_state_e : walk FSM encoding (IDLE -> RUN -> DONE -> IDLE)
//   idx_w(n)     : index width for a counter over n values, never below 1 bit
package dmem_addr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } agen_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_tile_addr_gen_wrap_counter.sv
// Modulo-MAX up counter with synchronous clear and load.
//   clk, rst  : clock, async active-high reset (value -> 0)
//   en        : advance by one, wrapping MAX-1 -> 0
//   clr       : force to 0 (highest priority)
//   load      : take load_val (beats en)
//   value     : current count
//   wrap      : value is MAX-1, so the next en wraps
module wrap_counter
  import dmem_addr_pkg::*;
#(
  parameter int unsigned MAX = 2,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] value_q, value_d;

  assign wrap  = (value_q == LAST);
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (clr)       value_d = '0;
    else if (load) value_d = load_val;
    else if (en)   value_d = wrap ? '0 : value_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

endmodule

// File: rtl/dmem_tile_addr_gen.sv
// Data-memory address generator for the binary MLP datapath.
// Walks NUM_BLK blocks of SUB_BLK words, for cfg_passes passes, rotating the
// starting block by ROT_STEP each pass, and issues one address per valid/ready
// handshake.
//   clk, rst                  : clock, async active-high reset
//   start, abort              : begin walk (IDLE only) / cancel walk
//   cfg_base, cfg_passes      : latched on an accepted start
//   addr_ready / addr_valid   : dmem read-port handshake
//   dmem_addr                 : base + blk*SUB_BLK + sub, mod 2**ADDR_W
//   blk_idx, sub_idx, pass_idx: current walk position
//   first_of_pass, last_of_pass, nxt_start_block : pass framing
//   busy, done                : not IDLE / one-cycle completion pulse
module dmem_tile_addr_gen
  import dmem_addr_pkg::*;
#(
  parameter  int unsigned ADDR_W   = 7,
  parameter  int unsigned NUM_BLK  = 8,
  parameter  int unsigned SUB_BLK  = 8,
  parameter  int unsigned PASS_W   = 4,
  parameter  int unsigned ROT_STEP = 1,
  localparam int unsigned BLK_W    = idx_w(NUM_BLK),
  localparam int unsigned SUB_W    = idx_w(SUB_BLK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              addr_ready,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [BLK_W-1:0]  blk_idx,
  output logic [SUB_W-1:0]  sub_idx,
  output logic [PASS_W-1:0] pass_idx,
  output logic              first_of_pass,
  output logic              last_of_pass,
  output logic [BLK_W-1:0]  nxt_start_block,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     ROT_MOD  = ROT_STEP % NUM_BLK;
  localparam logic [BLK_W:0]  NB_EXT   = (BLK_W + 1)'(NUM_BLK);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLK - 1);
  localparam bit              SUB_POW2 = ((SUB_BLK & (SUB_BLK - 1)) == 0);

  agen_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [BLK_W-1:0]  pass_start_q, pass_start_d;

  logic [SUB_W-1:0]  sub_q;
  logic [BLK_W-1:0]  blk_q;
  logic [PASS_W-1:0] pass_q;
  logic              sub_wrap, blk_wrap, pass_wrap;
  logic              unused_wraps;

  logic              run, fire, start_ok, pass_end, final_beat, clr_all;
  logic [BLK_W:0]    rot_sum;
  logic [BLK_W-1:0]  nxt_blk, last_blk;
  logic [ADDR_W-1:0] blk_off;

  assign unused_wraps = blk_wrap ^ pass_wrap;

  assign run      = (state_q == RUN);
  assign fire     = run & addr_ready;
  assign start_ok = (state_q == IDLE) & start & ~abort;

  // Start block of the next pass: one conditional subtract suffices since
  // both operands are already below NUM_BLK.
  assign rot_sum  = {1'b0, pass_start_q} + (BLK_W + 1)'(ROT_MOD);
  assign nxt_blk  = (rot_sum >= NB_EXT) ? BLK_W'(rot_sum - NB_EXT) : BLK_W'(rot_sum);
  assign last_blk = (pass_start_q == '0) ? LAST_BLK : pass_start_q - BLK_W'(1);

  assign pass_end   = sub_wrap & (blk_q == last_blk);
  assign final_beat = pass_end & (pass_q == passes_q - PASS_W'(1));
  // Counters return to zero whenever the walk starts, ends or is abandoned,
  // so idle index outputs read 0.
  assign clr_all    = start_ok | abort | (fire & final_beat);

  wrap_counter #(.MAX(SUB_BLK), .W(SUB_W)) u_sub (
    .clk(clk), .rst(rst), .en(fire), .clr(clr_all), .load(1'b0),
    .load_val('0), .value(sub_q), .wrap(sub_wrap)
  );

  // At a pass boundary blk jumps to the rotated start instead of incrementing.
  wrap_counter #(.MAX(NUM_BLK), .W(BLK_W)) u_blk (
    .clk(clk), .rst(rst), .en(fire & sub_wrap), .clr(clr_all),
    .load(fire & pass_end), .load_val(nxt_blk), .value(blk_q), .wrap(blk_wrap)
  );

  wrap_counter #(.MAX(2 ** PASS_W), .W(PASS_W)) u_pass (
    .clk(clk), .rst(rst), .en(fire & pass_end), .clr(clr_all), .load(1'b0),
    .load_val('0), .value(pass_q), .wrap(pass_wrap)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    passes_d     = passes_q;
    pass_start_d = pass_start_q;
    if (clr_all)              pass_start_d = '0;
    else if (fire & pass_end) pass_start_d = nxt_blk;
    case (state_q)
      IDLE: if (start_ok) begin
        base_d   = cfg_base;
        passes_d = cfg_passes;
        state_d  = (cfg_passes != '0) ? RUN : DONE;
      end
      RUN: begin
        if (abort)                   state_d = IDLE;
        else if (fire & final_beat)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      passes_q     <= '0;
      pass_start_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      passes_q     <= passes_d;
      pass_start_q <= pass_start_d;
    end
  end

  generate
    if (SUB_POW2) begin : g_shift
      assign blk_off = ADDR_W'(blk_q) << $clog2(SUB_BLK);
    end else begin : g_mul
      assign blk_off = ADDR_W'(blk_q) * ADDR_W'(SUB_BLK);
    end
  endgenerate

  assign addr_valid      = run;
  assign dmem_addr       = run ? base_q + blk_off + ADDR_W'(sub_q) : '0;
  assign blk_idx         = blk_q;
  assign sub_idx         = sub_q;
  assign pass_idx        = pass_q;
  assign first_of_pass   = run & (sub_q == '0) & (blk_q == pass_start_q);
  assign last_of_pass    = run & pass_end;
  assign busy            = (state_q != IDLE);
  assign nxt_start_block = busy ? nxt_blk : '0;
  // An abort landing in DONE suppresses the pulse in that same cycle.
  assign done            = (state_q == DONE) & ~abort;

endmodule

// File: tb/tb_dmem_tile_addr_gen.sv
module tb_dmem_tile_addr_gen;

  localparam int NB = 4;
  localparam int SB = 2;

  typedef struct {
    logic [6:0] addr;
    logic [1:0] blk;
    logic       sub;
    logic [3:0] pass;
    logic       first;
    logic       last;
    logic [1:0] nxt;
  } beat_t;

  logic       clk = 1'b0, rst = 1'b1, abort = 1'b0, addr_ready = 1'b0;
  logic       start1 = 1'b0, start0 = 1'b0;
  logic [6:0] cfg_base = '0;
  logic [3:0] cfg_passes = '0;

  logic v1, f1, l1, bz1, d1, s1;
  logic v0, f0, l0, bz0, d0, s0;
  logic [6:0] a1, a0;
  logic [1:0] b1, b0, n1, n0;
  logic [3:0] p1, p0;

  int n_vec = 0, n_err = 0, cyc = 0;
  int fires1 = 0, fires0 = 0, lastf1 = 0, lastf0 = 0;
  beat_t q1[$], q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_tile_addr_gen #(.ADDR_W(7), .NUM_BLK(4), .SUB_BLK(2), .PASS_W(4), .ROT_STEP(1)) dut (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .cfg_base(cfg_base),
    .cfg_passes(cfg_passes), .addr_ready(addr_ready), .addr_valid(v1), .dmem_addr(a1),
    .blk_idx(b1), .sub_idx(s1), .pass_idx(p1), .first_of_pass(f1), .last_of_pass(l1),
    .nxt_start_block(n1), .busy(bz1), .done(d1)
  );

  dmem_tile_addr_gen #(.ADDR_W(7), .NUM_BLK(4), .SUB_BLK(2), .PASS_W(4), .ROT_STEP(0)) dut_r0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .cfg_base(cfg_base),
    .cfg_passes(cfg_passes), .addr_ready(addr_ready), .addr_valid(v0), .dmem_addr(a0),
    .blk_idx(b0), .sub_idx(s0), .pass_idx(p0), .first_of_pass(f0), .last_of_pass(l0),
    .nxt_start_block(n0), .busy(bz0), .done(d0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input bit sel);  return sel ? d1 : d0;   endfunction
  function automatic logic get_busy(input bit sel);  return sel ? bz1 : bz0; endfunction
  function automatic logic get_valid(input bit sel); return sel ? v1 : v0;   endfunction
  function automatic int   get_fires(input bit sel); return sel ? fires1 : fires0; endfunction
  function automatic int   get_lastf(input bit sel); return sel ? lastf1 : lastf0; endfunction
  function automatic int   get_qsize(input bit sel); return sel ? q1.size() : q0.size(); endfunction

  task automatic push_model(input bit sel, input logic [6:0] b, input logic [3:0] p, input int rot);
    int ps = 0;
    beat_t e;
    for (int pi = 0; pi < int'(p); pi++) begin
      for (int k = 0; k < NB * SB; k++) begin
        e.blk   = 2'((ps + k / SB) % NB);
        e.sub   = 1'(k % SB);
        e.addr  = 7'(int'(b) + int'(e.blk) * SB + int'(e.sub));
        e.pass  = 4'(pi);
        e.first = (k == 0);
        e.last  = (k == NB * SB - 1);
        e.nxt   = 2'((ps + rot) % NB);
        if (sel) q1.push_back(e); else q0.push_back(e);
      end
      ps = (ps + rot) % NB;
    end
  endtask

  // Scoreboard heads are compared every valid cycle, so held outputs during
  // stalls are checked against the expected beat too.
  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) chk("beat1_unexpected", {31'b0, v1}, 32'd0);
      else begin
        chk("beat1_addr", 32'(a1), 32'(q1[0].addr));
        chk("beat1_idx", 32'({b1, s1, p1, f1, l1, n1}),
            32'({q1[0].blk, q1[0].sub, q1[0].pass, q1[0].first, q1[0].last, q1[0].nxt}));
        if (addr_ready) begin
          void'(q1.pop_front());
          fires1++;
          lastf1 = cyc;
        end
      end
    end
    if (v0) begin
      if (q0.size() == 0) chk("beat0_unexpected", {31'b0, v0}, 32'd0);
      else begin
        chk("beat0_addr", 32'(a0), 32'(q0[0].addr));
        chk("beat0_idx", 32'({b0, s0, p0, f0, l0, n0}),
            32'({q0[0].blk, q0[0].sub, q0[0].pass, q0[0].first, q0[0].last, q0[0].nxt}));
        if (addr_ready) begin
          void'(q0.pop_front());
          fires0++;
          lastf0 = cyc;
        end
      end
    end
  end

  task automatic run_walk(input bit sel, input logic [6:0] b, input logic [3:0] p,
                          input int rot, input bit toggle, input string nm);
    bit seen = 0;
    push_model(sel, b, p, rot);
    fires1 = 0;
    fires0 = 0;
    @(posedge clk); #1;
    cfg_base   = b;
    cfg_passes = p;
    addr_ready = 1'b1;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start0 = 1'b0;
    chk({nm, "_busy"}, 32'(get_busy(sel)), 32'd1);
    chk({nm, "_valid_lat"}, 32'(get_valid(sel)), (p != 0) ? 32'd1 : 32'd0);
    for (int c = 0; c < 400 && !seen; c++) begin
      if (toggle) addr_ready = (c % 2 == 0);
      if (p != 0 && c == 3) begin
        // restart attempt while busy with different config; must be ignored
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        cfg_base   = ~b;
        cfg_passes = 4'd1;
      end
      if (c == 4) begin
        start1     = 1'b0;
        start0     = 1'b0;
        cfg_base   = b;
        cfg_passes = p;
      end
      @(negedge clk);
      if (get_done(sel)) begin
        seen = 1;
        if (p == 0) chk({nm, "_zero_done_lat"}, 32'(c), 32'd0);
      end else begin
        @(posedge clk); #1;
      end
    end
    start1 = 1'b0;
    start0 = 1'b0;
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (p != 0) chk({nm, "_done_lat"}, 32'(cyc - get_lastf(sel)), 32'd1);
      chk({nm, "_fires"}, 32'(get_fires(sel)), 32'(NB * SB * int'(p)));
      @(posedge clk); #1;
      chk({nm, "_done_pulse"}, 32'(get_done(sel)), 32'd0);
      chk({nm, "_idle"}, 32'(get_busy(sel)), 32'd0);
    end
    chk({nm, "_sb_empty"}, 32'(get_qsize(sel)), 32'd0);
    q1.delete();
    q0.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs1", 32'({v1, a1, b1, s1, p1, f1, l1, n1, bz1, d1}), 32'd0);
    chk("reset_outs0", 32'({v0, a0, b0, s0, p0, f0, l0, n0, bz0, d0}), 32'd0);
    rst = 1'b0;

    run_walk(1'b1, 7'h10, 4'd2, 1, 1'b0, "t1_basic");
    run_walk(1'b1, 7'h10, 4'd2, 1, 1'b1, "t2_stall");
    run_walk(1'b1, 7'h10, 4'd0, 1, 1'b0, "t3_zero");
    run_walk(1'b1, 7'h7C, 4'd1, 1, 1'b0, "t4_wrap");

    // abort on the fifth beat, coincident with its fire
    push_model(1'b1, 7'h20, 4'd2, 1);
    fires1 = 0;
    @(posedge clk); #1;
    cfg_base = 7'h20; cfg_passes = 4'd2; addr_ready = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    chk("t5_valid_at_abort", 32'(v1), 32'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_idle_after_abort", 32'({v1, bz1, d1, b1, s1, p1}), 32'd0);
    chk("t5_fires", 32'(fires1), 32'd5);
    q1.delete();
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_done", 32'({d1, v1}), 32'd0);
    end
    run_walk(1'b1, 7'h10, 4'd2, 1, 1'b0, "t5_restart");

    // async reset in the middle of a pass
    push_model(1'b1, 7'h30, 4'd2, 1);
    @(posedge clk); #1;
    cfg_base = 7'h30; cfg_passes = 4'd2; addr_ready = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", 32'({v1, a1, b1, s1, p1, f1, l1, n1, bz1, d1}), 32'd0);
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_walk(1'b0, 7'h40, 4'd3, 0, 1'b0, "t6_rot0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
